program_loader: RTL and testbench

//   Byte-stream boot loader upstream of CPU_SingleCycle. Receives framed

---
 rtl/program_loader.sv | 138 +++++++++++++
 tb/tb_program_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream boot loader: parses framed write/run/stop commands and drives the
// instruction/data memory write ports, holding the CPU in reset while loading.
module program_loader #(
  parameter int IM_ADDR_W = 8,
  parameter int DM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 dm_we,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [31:0]          dm_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          word_count
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_A_HI  = 4'd1;
  localparam logic [3:0] S_A_LO  = 4'd2;
  localparam logic [3:0] S_D3    = 4'd3;
  localparam logic [3:0] S_D2    = 4'd4;
  localparam logic [3:0] S_D1    = 4'd5;
  localparam logic [3:0] S_D0    = 4'd6;
  localparam logic [3:0] S_WRITE = 4'd7;
  localparam logic [3:0] S_RUN   = 4'd8;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  localparam logic [7:0] CMD_STOP = 8'h04;

  logic [3:0]  state;
  logic        tgt_dm;
  logic [15:0] addr_q;
  logic [23:0] data_q;
  logic        wr_bad;
  logic        accept;
  logic [31:0] word_full;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Address is a 16-bit word address; anything at or above 2**width is out of range.
  function automatic logic addr_ok(input logic [15:0] a, input int width);
    return ({16'd0, a} < (32'd1 << width));
  endfunction

  assign in_ready  = rst | (state != S_WRITE);
  assign accept    = in_valid & in_ready;
  assign busy      = (state != S_IDLE) && (state != S_RUN);
  assign word_full = {data_q, in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cpu_rst    <= 1'b1;
      im_we      <= 1'b0;
      dm_we      <= 1'b0;
      im_addr    <= '0;
      dm_addr    <= '0;
      im_wdata   <= '0;
      dm_wdata   <= '0;
      error      <= 1'b0;
      word_count <= '0;
      tgt_dm     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_bad     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_IMEM: begin tgt_dm <= 1'b0; state <= S_A_HI; end
              CMD_DMEM: begin tgt_dm <= 1'b1; state <= S_A_HI; end
              CMD_RUN:  begin cpu_rst <= 1'b0; state <= S_RUN; end
              CMD_STOP: state <= S_IDLE;
              default:  error <= 1'b1;
            endcase
          end
        end
        S_A_HI: if (accept) begin addr_q[15:8] <= in_data; state <= S_A_LO; end
        S_A_LO: if (accept) begin addr_q[7:0]  <= in_data; state <= S_D3;   end
        S_D3:   if (accept) begin data_q <= {data_q[15:0], in_data}; state <= S_D2; end
        S_D2:   if (accept) begin data_q <= {data_q[15:0], in_data}; state <= S_D1; end
        S_D1:   if (accept) begin data_q <= {data_q[15:0], in_data}; state <= S_D0; end
        S_D0: begin
          // Port outputs are loaded here so they are valid for the whole WRITE cycle.
          if (accept) begin
            state <= S_WRITE;
            if (tgt_dm) begin
              if (addr_ok(addr_q, DM_ADDR_W)) begin
                dm_we    <= 1'b1;
                dm_addr  <= addr_q[DM_ADDR_W-1:0];
                dm_wdata <= word_full;
                wr_bad   <= 1'b0;
              end else begin
                wr_bad   <= 1'b1;
              end
            end else begin
              if (addr_ok(addr_q, IM_ADDR_W)) begin
                im_we    <= 1'b1;
                im_addr  <= addr_q[IM_ADDR_W-1:0];
                im_wdata <= word_full;
                wr_bad   <= 1'b0;
              end else begin
                wr_bad   <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          im_we <= 1'b0;
          dm_we <= 1'b0;
          state <= S_IDLE;
          if (wr_bad) error <= 1'b1;
          else        word_count <= sat_inc(word_count);
        end
        S_RUN: begin
          if (accept && in_data == CMD_STOP) begin
            cpu_rst <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: frame-level reference model with shadow
// memories, checked against the write strobes observed on the memory ports.
module tb_program_loader;

  logic        clk_tb = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we, dm_we;
  logic [7:0]  im_addr, dm_addr;
  logic [31:0] im_wdata, dm_wdata;
  logic        cpu_rst, busy, error;
  logic [15:0] word_count;

  always #5 clk_tb = ~clk_tb;

  program_loader #(.IM_ADDR_W(8), .DM_ADDR_W(8)) dut (
    .clk(clk_tb), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .cpu_rst(cpu_rst),
    .busy(busy), .error(error), .word_count(word_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int im_pulses = 0, dm_pulses = 0, both_high = 0;

  // Reference model state
  logic [31:0] tb_im [256];
  logic [31:0] tb_dm [256];
  logic [31:0] m_im  [256];
  logic [31:0] m_dm  [256];
  int          exp_im_pulses = 0, exp_dm_pulses = 0;
  int          exp_count = 0;
  logic        exp_error = 1'b0;

  always @(posedge clk_tb) cyc <= cyc + 1;

  always @(negedge clk_tb) begin
    if (im_we === 1'b1) begin tb_im[im_addr] = im_wdata; im_pulses++; end
    if (dm_we === 1'b1) begin tb_dm[dm_addr] = dm_wdata; dm_pulses++; end
    if (im_we === 1'b1 && dm_we === 1'b1) both_high++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk_tb);
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk_tb);
    rst = 1'b0;
    exp_count = 0;
    exp_error = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_tb);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_tb);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk_tb);
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (in_ready !== 1'b1 && tries < 16) begin
      @(negedge clk_tb);
      tries++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk_tb);
    #1;
    last_acc = cyc;
  endtask

  // Frame-level model: a write lands iff the word address fits the memory.
  task automatic model_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] data);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      if (addr < 16'd256) begin
        if (cmd == 8'h01) begin m_im[addr[7:0]] = data; exp_im_pulses++; end
        else              begin m_dm[addr[7:0]] = data; exp_dm_pulses++; end
        if (exp_count < 65535) exp_count++;
      end else begin
        exp_error = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [31:0] data, input int gap_max);
    logic [7:0] bytes [7];
    bytes[0] = cmd;        bytes[1] = addr[15:8]; bytes[2] = addr[7:0];
    bytes[3] = data[31:24]; bytes[4] = data[23:16];
    bytes[5] = data[15:8];  bytes[6] = data[7:0];
    for (int i = 0; i < 7; i++)
      send_byte(bytes[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    model_frame(cmd, addr, data);
  endtask

  task automatic test_reset();
    @(negedge clk_tb);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk_tb);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk_tb);
    rst = 1'b0;
    exp_count = 0; exp_error = 1'b0;
    @(negedge clk_tb);
    total++;
    if ({cpu_rst, im_we, dm_we, busy, error} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl: cpu_rst/im_we/dm_we/busy/error=%b want 10000",
                      {cpu_rst, im_we, dm_we, busy, error});
    end
    total++;
    if (word_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", word_count); end
    total++;
    if ({im_addr, dm_addr, im_wdata, dm_wdata} !== 80'd0) begin
      bad++; $display("FAIL reset_ports: im_addr=%h dm_addr=%h im_wdata=%h dm_wdata=%h want 0",
                      im_addr, dm_addr, im_wdata, dm_wdata);
    end
  endtask

  task automatic test_imem_write();
    send_frame(8'h01, 16'h0000, 32'h20100200, 0);
    idle(2);
    total++;
    if (im_pulses !== exp_im_pulses || dm_pulses !== exp_dm_pulses) begin
      bad++; $display("FAIL imem_pulses: im=%0d dm=%0d want im=%0d dm=%0d",
                      im_pulses, dm_pulses, exp_im_pulses, exp_dm_pulses);
    end
    total++;
    if (im_addr !== 8'h00 || im_wdata !== 32'h20100200) begin
      bad++; $display("FAIL imem_word: addr=%h data=%h want 00 20100200", im_addr, im_wdata);
    end
    total++;
    if (word_count !== 16'(exp_count)) begin bad++; $display("FAIL imem_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_dmem_write();
    send_frame(8'h02, 16'h0080, 32'h00000037, 0);
    idle(2);
    total++;
    if (dm_pulses !== exp_dm_pulses || im_pulses !== exp_im_pulses) begin
      bad++; $display("FAIL dmem_pulses: im=%0d dm=%0d want im=%0d dm=%0d",
                      im_pulses, dm_pulses, exp_im_pulses, exp_dm_pulses);
    end
    total++;
    if (dm_addr !== 8'h80 || dm_wdata !== 32'h00000037) begin
      bad++; $display("FAIL dmem_word: addr=%h data=%h want 80 00000037", dm_addr, dm_wdata);
    end
    total++;
    if (word_count !== 16'(exp_count)) begin bad++; $display("FAIL dmem_count: got %0d want %0d", word_count, exp_count); end
  endtask

  task automatic test_range();
    send_frame(8'h01, 16'h0100, 32'hDEADBEEF, 0);
    send_frame(8'h02, 16'hFFFF, 32'h12345678, 0);
    idle(2);
    total++;
    if (im_pulses !== exp_im_pulses || dm_pulses !== exp_dm_pulses) begin
      bad++; $display("FAIL range_suppress: im=%0d dm=%0d want im=%0d dm=%0d",
                      im_pulses, dm_pulses, exp_im_pulses, exp_dm_pulses);
    end
    total++;
    if (error !== 1'b1 || word_count !== 16'(exp_count)) begin
      bad++; $display("FAIL range_error: error=%b count=%0d want 1 %0d", error, word_count, exp_count);
    end
    send_frame(8'h01, 16'h0005, 32'hCAFEF00D, 0);
    idle(2);
    total++;
    if (im_addr !== 8'h05 || im_wdata !== 32'hCAFEF00D || word_count !== 16'(exp_count)) begin
      bad++; $display("FAIL range_recover: addr=%h data=%h count=%0d want 05 cafef00d %0d",
                      im_addr, im_wdata, word_count, exp_count);
    end
  endtask

  task automatic test_bad_cmd();
    apply_reset();
    send_byte(8'h7E, 0);
    idle(2);
    total++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL badcmd_error: error=%b busy=%b want 1 0", error, busy);
    end
    send_frame(8'h01, 16'h0003, 32'hA5A5_0003, 0);
    idle(2);
    total++;
    if (im_addr !== 8'h03 || im_wdata !== 32'hA5A50003 || im_pulses !== exp_im_pulses || error !== 1'b1) begin
      bad++; $display("FAIL badcmd_next: addr=%h data=%h pulses=%0d error=%b want 03 a5a50003 %0d 1",
                      im_addr, im_wdata, im_pulses, exp_im_pulses, error);
    end
  endtask

  task automatic test_random_gaps();
    int mism;
    apply_reset();
    exp_error = 1'b0;
    for (int f = 0; f < 40; f++) begin
      logic [7:0]  cmd;
      logic [15:0] addr;
      cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      addr = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) send_byte(8'h04, $urandom_range(0, 2));
      send_frame(cmd, addr, $urandom, 3);
    end
    idle(3);
    total++;
    if (im_pulses !== exp_im_pulses || dm_pulses !== exp_dm_pulses || both_high !== 0) begin
      bad++; $display("FAIL gaps_pulses: im=%0d dm=%0d both=%0d want im=%0d dm=%0d both=0",
                      im_pulses, dm_pulses, both_high, exp_im_pulses, exp_dm_pulses);
    end
    total++;
    if (word_count !== 16'(exp_count) || error !== exp_error) begin
      bad++; $display("FAIL gaps_status: count=%0d error=%b want %0d %b", word_count, error, exp_count, exp_error);
    end
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      if (tb_im[i] !== m_im[i]) mism++;
      if (tb_dm[i] !== m_dm[i]) mism++;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL gaps_memory: %0d words differ, want 0", mism); end
  endtask

  task automatic test_back_to_back();
    int prev_acc;
    apply_reset();
    prev_acc = 0;
    for (int f = 0; f < 4; f++) begin
      logic [7:0] cmd;
      cmd = (f[0]) ? 8'h02 : 8'h01;
      send_frame(cmd, 16'(8'h40 + f), $urandom, 0);
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || im_we !== (cmd == 8'h01) || dm_we !== (cmd == 8'h02)) begin
        bad++; $display("FAIL b2b_write_cycle: in_ready=%b busy=%b im_we=%b dm_we=%b want 0 1 %b %b",
                        in_ready, busy, im_we, dm_we, cmd == 8'h01, cmd == 8'h02);
      end
      if (f > 0) begin
        total++;
        if (last_acc - prev_acc != 8) begin
          bad++; $display("FAIL b2b_throughput: %0d cycles per frame want 8", last_acc - prev_acc);
        end
      end
      prev_acc = last_acc;
    end
    idle(2);
    total++;
    if (im_pulses !== exp_im_pulses || dm_pulses !== exp_dm_pulses || word_count !== 16'(exp_count)) begin
      bad++; $display("FAIL b2b_pulses: im=%0d dm=%0d count=%0d want %0d %0d %0d",
                      im_pulses, dm_pulses, word_count, exp_im_pulses, exp_dm_pulses, exp_count);
    end
  endtask

  task automatic test_run_stop();
    int mism;
    int im_before, dm_before;
    apply_reset();
    for (int i = 0; i < 27; i++) send_frame(8'h01, 16'(i), $urandom, 1);
    for (int i = 0; i < 13; i++) send_frame(8'h02, 16'(128 + i), $urandom, 1);
    idle(2);
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      if (tb_im[i] !== m_im[i]) mism++;
      if (tb_dm[i] !== m_dm[i]) mism++;
    end
    total++;
    if (mism != 0 || word_count !== 16'd40 || cpu_rst !== 1'b1) begin
      bad++; $display("FAIL load_program: diffs=%0d count=%0d cpu_rst=%b want 0 40 1", mism, word_count, cpu_rst);
    end
    send_byte(8'h03, 0);
    total++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL run_release: cpu_rst=%b busy=%b want 0 0", cpu_rst, busy);
    end
    im_before = im_pulses; dm_before = dm_pulses;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h04) b = 8'h01;
      send_byte(b, $urandom_range(0, 1));
    end
    idle(2);
    total++;
    if (cpu_rst !== 1'b0 || im_pulses !== im_before || dm_pulses !== dm_before || error !== 1'b0) begin
      bad++; $display("FAIL run_ignore: cpu_rst=%b im=%0d dm=%0d error=%b want 0 %0d %0d 0",
                      cpu_rst, im_pulses, dm_pulses, error, im_before, dm_before);
    end
    send_byte(8'h04, 0);
    total++;
    if (cpu_rst !== 1'b1) begin bad++; $display("FAIL stop_hold: cpu_rst=%b want 1", cpu_rst); end
    send_frame(8'h01, 16'h0020, 32'h0BADF00D, 0);
    idle(2);
    total++;
    if (im_addr !== 8'h20 || im_wdata !== 32'h0BADF00D || im_pulses !== exp_im_pulses) begin
      bad++; $display("FAIL stop_then_write: addr=%h data=%h pulses=%0d want 20 0badf00d %0d",
                      im_addr, im_wdata, im_pulses, exp_im_pulses);
    end
  endtask

  task automatic test_mid_reset();
    int im_before;
    apply_reset();
    im_before = im_pulses;
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: busy=%b want 1", busy); end
    apply_reset();
    idle(3);
    total++;
    if (im_pulses !== im_before || busy !== 1'b0 || cpu_rst !== 1'b1 || word_count !== 16'd0) begin
      bad++; $display("FAIL midrst_discard: pulses=%0d busy=%b cpu_rst=%b count=%0d want %0d 0 1 0",
                      im_pulses, busy, cpu_rst, word_count, im_before);
    end
    send_frame(8'h01, 16'h0007, 32'h11223344, 0);
    idle(2);
    total++;
    if (im_addr !== 8'h07 || im_wdata !== 32'h11223344 || word_count !== 16'd1 || cpu_rst !== 1'b1) begin
      bad++; $display("FAIL midrst_fresh: addr=%h data=%h count=%0d cpu_rst=%b want 07 11223344 1 1",
                      im_addr, im_wdata, word_count, cpu_rst);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tb_im[i] = 32'd0; tb_dm[i] = 32'd0; m_im[i] = 32'd0; m_dm[i] = 32'd0;
    end
    test_reset();
    test_imem_write();
    test_dmem_write();
    test_range();
    test_bad_cmd();
    test_random_gaps();
    test_back_to_back();
    test_run_stop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
